pipe_field_scroller: RTL and testbench
======================================

Name: pipe_field_scroller

Overview:
- Parametrised ROWS x COLS scrolling LED field for the pipe animation.
- Generates its own pipe columns: spacing/pipe FSM, gap position, built-in step divider.
- Reports bird collision and pipe-passed events to game control; feeds the LED driver directly.

Parameters:
- ROWS, 16, field height in rows.
- COLS, 16, field width in columns; column 0 is the entry (right) edge.
- DIV_BITS, 10, step divider width; one scroll step every 2^DIV_BITS enabled clocks.
- PIPE_SPACING, 6, empty columns emitted between pipes (>=1).
- PIPE_W, 2, columns per pipe (>=1).
- GAP_H, 4, gap height in rows (1..ROWS-1).
- BIRD_COL, 12, column the bird occupies (1..COLS-1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run scrolling; low freezes divider, FSM and field
- gap_row  in  $clog2(ROWS)  top row of the next pipe's gap
- bird_row  in  $clog2(ROWS)  current bird row
- field  out  ROWS*COLS  LED state; bit r*COLS+c = row r, column c
- step  out  1  one-cycle pulse, the cycle after each scroll
- collision  out  1  registered: field bit (bird_row, BIRD_COL) set
- pass  out  1  one-cycle pulse when a pipe's trailing edge leaves BIRD_COL

Behaviour:
- Reset values:
  - field=0, step=0, collision=0, pass=0.
  - Divider=0, FSM=SPACE, column counter=0, latched gap=0.
  - Reset mid-operation clears everything on the next edge.
- Divider:
  - Increments only when enable=1.
  - A shift edge is an edge where enable=1 and divider=all-ones; the divider wraps to 0 on that edge.
  - step=1 in the following cycle only.
- Shift, on each shift edge for every row r:
  - field[r][c] <= field[r][c-1] for c>=1.
  - field[r][0] <= new_col[r].
  - Column COLS-1 is discarded.
- Column FSM, advanced only on shift edges:
  - SPACE: new_col=0; counter increments. After PIPE_SPACING columns, go to PIPE and reset counter.
  - Latch: on the SPACE->PIPE transition, latched gap <= min(gap_row, ROWS-GAP_H).
  - PIPE: new_col[r]=1 except latched_gap <= r < latched_gap+GAP_H. After PIPE_W columns, go to SPACE and reset counter.
  - gap_row changes during PIPE have no effect on the current pipe.
- collision: registered every clock, regardless of enable, from the current field and bird_row; 1-cycle latency.
- pass:
  - Asserted the cycle after a shift edge where, before the shift, column BIRD_COL was non-zero and column BIRD_COL-1 was zero.
  - Asserted coincident with step.
- enable=0:
  - All state holds; step and pass stay 0.
  - collision keeps tracking bird_row.
- Boundary cases:
  - gap_row > ROWS-GAP_H is clamped.
  - gap_row=0 gives a gap at rows 0..GAP_H-1.
  - PIPE_W>=COLS-BIRD_COL is legal; pass fires only on the trailing edge.

Optional Feature:
- Macro: PIPE_RANDOM_GAP_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
  - Advances on every shift edge.
  - Latched gap = lfsr mod (ROWS-GAP_H+1); gap_row is ignored.
- Undefined: no LFSR; gap_row is used as above. The port list is identical in both builds.

Test Plan:
- Reset check:
  - Setup: defaults; drive random inputs, then hold reset 2 cycles.
  - Required response: field=0, step=0, pass=0, collision=0, and divider/FSM restart from zero.
- Step timing:
  - Setup: DIV_BITS=2, enable=1 from cycle 0.
  - Required response: step high in cycles 4, 8, 12. Dropping enable for 3 cycles after cycle 5 moves the next step to cycle 11.
- Pipe generation:
  - Setup: ROWS=8, COLS=8, DIV_BITS=1, PIPE_SPACING=2, PIPE_W=1, GAP_H=3, gap_row=2.
  - After steps 1-2: column 0 = 0.
  - After step 3: column 0 rows {0,1,5,6,7}=1, rows 2..4=0.
  - After step 4: that pattern sits in column 1.
- Clamp and latch:
  - Same config with gap_row=7: the pipe gap is rows 5..7.
  - Changing gap_row during PIPE with PIPE_W=2: both pipe columns are identical.
- Collision and pass:
  - Setup: BIRD_COL=5, bird_row=0, pipe as in scenario 3.
  - collision=1 exactly one cycle after the pipe enters column 5; collision=0 with bird_row=3.
  - pass pulses once, with step, when the pipe moves 5->6.
- Random gap: PIPE_RANDOM_GAP_EN defined, default parameters; the first four pipe gaps match the LFSR model from seed 8'hA5, with gap_row held at 0.

Source files
------------

// File: rtl/pipe_field_scroller.sv
// pipe_field_scroller: ROWS x COLS scrolling LED field for the pipe animation.
// Generates pipe columns (space/pipe FSM with a latched gap), scrolls them in
// from column 0 once every 2^DIV_BITS enabled clocks, and reports bird
// collision and pipe-passed events.
// Optional build macro PIPE_RANDOM_GAP_EN: gap position comes from an internal
// 8-bit LFSR instead of the gap_row input (port list unchanged).
module pipe_field_scroller #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int DIV_BITS     = 10,
    parameter int PIPE_SPACING = 6,
    parameter int PIPE_W       = 2,
    parameter int GAP_H        = 4,
    parameter int BIRD_COL     = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [$clog2(ROWS)-1:0]  gap_row,
    input  logic [$clog2(ROWS)-1:0]  bird_row,
    output logic [ROWS*COLS-1:0]     field,
    output logic                     step,
    output logic                     collision,
    output logic                     pass
);
    localparam int RW      = $clog2(ROWS);
    localparam int CNT_MAX = (PIPE_SPACING > PIPE_W) ? PIPE_SPACING : PIPE_W;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [RW-1:0] GAP_MAX    = RW'(ROWS - GAP_H);
    localparam logic [CW-1:0] SPACE_LAST = CW'(PIPE_SPACING - 1);
    localparam logic [CW-1:0] PIPE_LAST  = CW'(PIPE_W - 1);

    typedef enum logic {
        ST_SPACE = 1'b0,
        ST_PIPE  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         gap_q, gap_d;
    logic [DIV_BITS-1:0]   div_q, div_d;
    logic [ROWS*COLS-1:0]  field_q, field_d;
    logic                  step_q, step_d;
    logic                  collision_q, collision_d;
    logic                  pass_q, pass_d;

    logic                  shift_edge;
    logic [ROWS-1:0]       new_col;
    logic [RW-1:0]         gap_pick;
    logic                  bird_col_set;
    logic                  prev_col_set;

    // A scroll happens on the enabled edge where the divider is about to wrap.
    assign shift_edge = enable && (div_q == '1);

`ifdef PIPE_RANDOM_GAP_EN
    localparam logic [7:0] GAP_MOD = 8'(ROWS - GAP_H + 1);

    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] lfsr_mod;
    logic       unused_gap_row;

    // gap_row is deliberately ignored in this build.
    assign unused_gap_row = ^gap_row;

    // LFSR x^8+x^6+x^5+x^4+1 steps once per scroll; its current value picks the gap.
    always_comb begin
        lfsr_d = lfsr_q;
        if (shift_edge) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
        lfsr_mod = lfsr_q % GAP_MOD;
        gap_pick = RW'(lfsr_mod);
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Clamp the requested gap so the whole gap fits inside the field.
    always_comb begin
        gap_pick = (gap_row > GAP_MAX) ? GAP_MAX : gap_row;
    end
`endif

    // Divider, step pulse and pass detection (pass looks at the pre-shift field).
    always_comb begin
        div_d  = div_q;
        step_d = 1'b0;
        pass_d = 1'b0;
        if (enable) begin
            div_d = div_q + DIV_BITS'(1);
        end
        if (shift_edge) begin
            step_d = 1'b1;
            pass_d = bird_col_set && !prev_col_set;
        end
    end

    // Occupancy of the bird column and its entry-side neighbour, plus collision lookup.
    always_comb begin
        bird_col_set = 1'b0;
        prev_col_set = 1'b0;
        collision_d  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            bird_col_set = bird_col_set | field_q[r*COLS + BIRD_COL];
            prev_col_set = prev_col_set | field_q[r*COLS + BIRD_COL - 1];
            if (bird_row == RW'(r)) begin
                collision_d = field_q[r*COLS + BIRD_COL];
            end
        end
    end

    // Column FSM: emits PIPE_SPACING empty columns then PIPE_W pipe columns.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        new_col = '0;
        if (state_q == ST_PIPE) begin
            for (int r = 0; r < ROWS; r++) begin
                new_col[r] = !((r >= int'(gap_q)) && (r < int'(gap_q) + GAP_H));
            end
        end
        if (shift_edge) begin
            case (state_q)
                ST_SPACE: begin
                    if (cnt_q == SPACE_LAST) begin
                        state_d = ST_PIPE;
                        cnt_d   = '0;
                        // Gap is frozen here so the whole pipe shares one gap.
                        gap_d   = gap_pick;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PIPE: begin
                    if (cnt_q == PIPE_LAST) begin
                        state_d = ST_SPACE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_SPACE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Field scroll: each row moves one column away from the entry edge.
    always_comb begin
        field_d = field_q;
        if (shift_edge) begin
            for (int r = 0; r < ROWS; r++) begin
                field_d[r*COLS] = new_col[r];
                for (int c = 1; c < COLS; c++) begin
                    field_d[r*COLS + c] = field_q[r*COLS + c - 1];
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SPACE;
            cnt_q       <= '0;
            gap_q       <= '0;
            div_q       <= '0;
            field_q     <= '0;
            step_q      <= 1'b0;
            collision_q <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            div_q       <= div_d;
            field_q     <= field_d;
            step_q      <= step_d;
            collision_q <= collision_d;
            pass_q      <= pass_d;
        end
    end

    assign field     = field_q;
    assign step      = step_q;
    assign collision = collision_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_pipe_field_scroller.sv
// Bench for pipe_field_scroller: directed scenarios plus randomized runs
// checked against a column-sequence reference model.
module tb_pipe_field_scroller;
    localparam int R    = 8;
    localparam int C    = 8;
    localparam int DB   = 2;
    localparam int SP   = 2;
    localparam int PW   = 2;
    localparam int GH   = 3;
    localparam int BC   = 5;
    localparam int DIVN = 1 << DB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [2:0]   gap_row = '0;
    logic [2:0]   bird_row = '0;
    logic [R*C-1:0] field;
    logic         step;
    logic         collision;
    logic         pass;

    pipe_field_scroller #(
        .ROWS(R), .COLS(C), .DIV_BITS(DB), .PIPE_SPACING(SP),
        .PIPE_W(PW), .GAP_H(GH), .BIRD_COL(BC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .gap_row(gap_row),
        .bird_row(bird_row), .field(field), .step(step),
        .collision(collision), .pass(pass)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_ok  = 0;

    // Reference model state
    bit         mf [R][C];
    int         m_en_cnt;
    int         m_ncol;
    int         m_gap;
    logic [7:0] m_lfsr;
    bit         e_step, e_pass, e_coll;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [R*C-1:0] model_field();
        logic [R*C-1:0] f;
        f = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                f[r*C + c] = mf[r][c];
        return f;
    endfunction

    function automatic logic [R-1:0] col_of(input logic [R*C-1:0] f, input int c);
        logic [R-1:0] v;
        for (int r = 0; r < R; r++) v[r] = f[r*C + c];
        return v;
    endfunction

    // Pipe column with its gap starting at row g.
    function automatic logic [R-1:0] pipe_pat(input int g);
        logic [R-1:0] v;
        for (int r = 0; r < R; r++) v[r] = !(r >= g && r < g + GH);
        return v;
    endfunction

    // Expected state after the coming clock edge, from the pre-edge model.
    task automatic model_update(input bit rst, input bit en, input int gr, input int br);
        int pos;
        bit sh, occ_b, occ_p;
        bit nc [R];
        if (rst) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) mf[r][c] = 0;
            m_en_cnt = 0; m_ncol = 0; m_gap = 0; m_lfsr = 8'hA5;
            e_step = 0; e_pass = 0; e_coll = 0;
        end else begin
            e_coll = mf[br][BC];
            sh = en && (m_en_cnt % DIVN == DIVN - 1);
            if (en) m_en_cnt++;
            e_step = sh;
            e_pass = 0;
            if (sh) begin
                occ_b = 0; occ_p = 0;
                for (int r = 0; r < R; r++) begin
                    occ_b |= mf[r][BC];
                    occ_p |= mf[r][BC-1];
                end
                e_pass = occ_b && !occ_p;
                pos = m_ncol % (SP + PW);
                for (int r = 0; r < R; r++)
                    nc[r] = (pos >= SP) && !(r >= m_gap && r < m_gap + GH);
                if (pos == SP - 1) begin
`ifdef PIPE_RANDOM_GAP_EN
                    m_gap = int'(m_lfsr) % (R - GH + 1);
`else
                    m_gap = (gr > R - GH) ? R - GH : gr;
`endif
                end
                m_lfsr = lfsr_next(m_lfsr);
                for (int r = 0; r < R; r++) begin
                    for (int c = C - 1; c >= 1; c--) mf[r][c] = mf[r][c-1];
                    mf[r][0] = nc[r];
                end
                m_ncol++;
            end
        end
    endtask

    task automatic tick(input bit rst, input bit en, input int gr, input int br);
        @(negedge clk);
        reset = rst; enable = en; gap_row = 3'(gr); bird_row = 3'(br);
        model_update(rst, en, gr, br);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 25; i++)
            tick(0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        n_chk++; if (field !== '0) $display("FAIL reset_field got %h exp 0", field); else n_ok++;
        n_chk++; if (step !== 1'b0) $display("FAIL reset_step got %b exp 0", step); else n_ok++;
        n_chk++; if (pass !== 1'b0) $display("FAIL reset_pass got %b exp 0", pass); else n_ok++;
        n_chk++; if (collision !== 1'b0) $display("FAIL reset_coll got %b exp 0", collision); else n_ok++;
    endtask

    task automatic test_step_timing();
        bit en, exp;
        // Continuous enable: steps in cycles 4, 8, 12.
        tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        for (int cyc = 0; cyc <= 12; cyc++) begin
            tick(0, 1, 0, 0);
            exp = (cyc + 1 == 4) || (cyc + 1 == 8) || (cyc + 1 == 12);
            n_chk++;
            if (step !== exp) $display("FAIL step_cont cycle %0d got %b exp %b", cyc + 1, step, exp);
            else n_ok++;
        end
        // Enable dropped in cycles 6..8: steps in cycles 4 and 11.
        tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        for (int cyc = 0; cyc <= 12; cyc++) begin
            en = !(cyc >= 6 && cyc <= 8);
            tick(0, en, 0, 0);
            exp = (cyc + 1 == 4) || (cyc + 1 == 11);
            n_chk++;
            if (step !== exp) $display("FAIL step_gated cycle %0d got %b exp %b", cyc + 1, step, exp);
            else n_ok++;
        end
    endtask

    task automatic test_pipe_generation();
        int steps = 0, cyc = 0, g;
        logic [R-1:0] col0, col1;
        tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        while (steps < 4 && cyc < 100) begin
            tick(0, 1, 2, 0);
            cyc++;
            if (step) begin
                steps++;
`ifdef PIPE_RANDOM_GAP_EN
                g = m_gap;
`else
                g = 2;
`endif
                col0 = col_of(field, 0);
                col1 = col_of(field, 1);
                if (steps <= 2) begin
                    n_chk++;
                    if (col0 !== '0) $display("FAIL pipe_space step %0d col0 got %b exp 0", steps, col0);
                    else n_ok++;
                end else if (steps == 3) begin
                    n_chk++;
                    if (col0 !== pipe_pat(g)) $display("FAIL pipe_enter col0 got %b exp %b", col0, pipe_pat(g));
                    else n_ok++;
                end else begin
                    n_chk++;
                    if (col1 !== pipe_pat(g)) $display("FAIL pipe_move col1 got %b exp %b", col1, pipe_pat(g));
                    else n_ok++;
                end
            end
        end
        if (steps < 4) begin
            n_chk++;
            $display("FAIL pipe_timeout steps got %0d exp 4", steps);
        end
    endtask

    task automatic test_clamp_latch();
        int steps = 0, cyc = 0, g, gr;
        logic [R-1:0] col0, col1;
        tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        while (steps < 4 && cyc < 100) begin
            gr = (steps < 2) ? 7 : $urandom_range(0, 4);
            tick(0, 1, gr, 0);
            cyc++;
            if (step) steps++;
        end
        if (steps < 4) begin
            n_chk++;
            $display("FAIL clamp_timeout steps got %0d exp 4", steps);
        end else begin
`ifdef PIPE_RANDOM_GAP_EN
            g = m_gap;
`else
            g = 5;
`endif
            col0 = col_of(field, 0);
            col1 = col_of(field, 1);
            n_chk++;
            if (col1 !== pipe_pat(g)) $display("FAIL clamp_gap col1 got %b exp %b", col1, pipe_pat(g));
            else n_ok++;
            n_chk++;
            if (col0 !== col1) $display("FAIL latch_same col0 got %b exp %b", col0, col1);
            else n_ok++;
        end
    endtask

    task automatic test_collision_pass();
        int npass = 0, epass = 0;
        tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            tick(0, 1, 2, (i < 60) ? 0 : 3);
            if (pass) npass++;
            if (e_pass) epass++;
            n_chk++;
            if (collision !== e_coll) $display("FAIL coll cycle %0d got %b exp %b", i, collision, e_coll);
            else n_ok++;
            n_chk++;
            if (pass !== e_pass) $display("FAIL pass cycle %0d got %b exp %b", i, pass, e_pass);
            else n_ok++;
        end
        n_chk++;
        if (npass !== epass) $display("FAIL pass_count got %0d exp %0d", npass, epass);
        else n_ok++;
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7));
            n_chk++;
            if (field !== model_field()) $display("FAIL rand_field got %h exp %h", field, model_field());
            else n_ok++;
            n_chk++;
            if (step !== e_step) $display("FAIL rand_step got %b exp %b", step, e_step);
            else n_ok++;
            n_chk++;
            if (pass !== e_pass) $display("FAIL rand_pass got %b exp %b", pass, e_pass);
            else n_ok++;
            n_chk++;
            if (collision !== e_coll) $display("FAIL rand_coll got %b exp %b", collision, e_coll);
            else n_ok++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            tick(0, 1, $urandom_range(0, 7), $urandom_range(0, 7));
        tick(1, 1, 3, 3);
        n_chk++;
        if ({field, step, pass, collision} !== '0)
            $display("FAIL midreset got %h/%b%b%b exp 0", field, step, pass, collision);
        else n_ok++;
        test_random(100);
    endtask

    initial begin
        tick(1, 0, 0, 0);
        test_reset();
        test_step_timing();
        test_pipe_generation();
        test_clamp_latch();
        test_collision_pass();
        tick(1, 0, 0, 0);
        test_random(400);
        test_back_to_back();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
